// File: rtl/fetch_align_pkg.sv
// Shared types and constants for the halfword fetch aligner.
package fetch_align_pkg;
  localparam int HALF_W      = 16;
  localparam int WORD_W      = 32;
  localparam int HADDR_W_DEF = 31;

  typedef logic [HADDR_W_DEF-2:0] waddr_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HI   = 1'b1
  } state_e;
endpackage

// File: rtl/fa_linebuf.sv
// One-entry line buffer: valid/tag/data registers with two hit-compare ports.
module fa_linebuf
  import fetch_align_pkg::*;
#(
  parameter int TAG_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inv_i,
  input  logic              we_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [TAG_W-1:0]  tag_a_i,
  input  logic [TAG_W-1:0]  tag_b_i,
  output logic              hit_a_o,
  output logic              hit_b_o,
  output logic [WORD_W-1:0] data_o
);
  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WORD_W-1:0] data_q, data_d;

  // An invalidate in the same cycle hides the entry and drops any fill.
  assign hit_a_o = valid_q && !inv_i && (tag_q == tag_a_i);
  assign hit_b_o = valid_q && !inv_i && (tag_q == tag_b_i);
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inv_i) begin
      valid_d = 1'b0;
    end else if (we_i) begin
      valid_d = 1'b1;
      tag_d   = wtag_i;
      data_d  = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/fetch_aligner.sv
// Halfword-granular fetch into one or two word cache reads; optional line buffer
// enabled by FETCH_ALIGN_LINEBUF_EN.
module fetch_aligner
  import fetch_align_pkg::*;
#(
  parameter int HADDR_W = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ren,
  input  logic                 i_wen,
  input  logic [HADDR_W-1:0]   i_addr,
  input  logic [WORD_W-1:0]    i_wdata,
  input  logic                 i_inv,
  output logic                 i_stall,
  output logic [WORD_W-1:0]    i_rdata,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic [HADDR_W-2:0]   mem_addr,
  output logic [WORD_W-1:0]    mem_wdata,
  input  logic                 mem_stall,
  input  logic [WORD_W-1:0]    mem_rdata
);
  localparam int WA_W = HADDR_W - 1;

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   hold_q, hold_d;
  logic [HADDR_W-1:0]  addr_q, addr_d;

  logic [WA_W-1:0]     w_addr, w1_addr;
  logic                odd;
  logic                hit_w, hit_w1;
  logic [WORD_W-1:0]   buf_data;
  logic                buf_we;
  logic [WA_W-1:0]     buf_wtag;
  logic [WORD_W-1:0]   buf_wdata;

  assign w_addr    = i_addr[HADDR_W-1:1];
  assign w1_addr   = w_addr + {{(WA_W-1){1'b0}}, 1'b1};
  assign odd       = i_addr[0];
  assign mem_wen   = 1'b0;
  assign mem_wdata = '0;

`ifdef FETCH_ALIGN_LINEBUF_EN
  fa_linebuf #(.TAG_W(WA_W)) u_linebuf (
    .clk     (clk),
    .rst     (rst),
    .inv_i   (i_inv),
    .we_i    (buf_we),
    .wtag_i  (buf_wtag),
    .wdata_i (buf_wdata),
    .tag_a_i (w_addr),
    .tag_b_i (w1_addr),
    .hit_a_o (hit_w),
    .hit_b_o (hit_w1),
    .data_o  (buf_data)
  );
`else
  assign hit_w    = 1'b0;
  assign hit_w1   = 1'b0;
  assign buf_data = '0;
  logic unused_linebuf;
  assign unused_linebuf = ^{i_inv, buf_we, buf_wtag, buf_wdata};
`endif

  logic unused_wport;
  assign unused_wport = ^{i_wen, i_wdata};

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    addr_d    = addr_q;
    mem_ren   = 1'b0;
    mem_addr  = w_addr;
    i_stall   = 1'b0;
    i_rdata   = '0;
    buf_we    = 1'b0;
    buf_wtag  = w_addr;
    buf_wdata = mem_rdata;
    if (rst) begin
      state_d = S_IDLE;
    end else if (!i_ren) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!odd) begin
            if (hit_w) begin
              i_rdata = buf_data;
            end else begin
              mem_ren = 1'b1;
              i_rdata = mem_rdata;
              i_stall = mem_stall;
              buf_we  = !mem_stall;
            end
          end else if (hit_w) begin
            mem_ren  = 1'b1;
            mem_addr = w1_addr;
            i_rdata  = {buf_data[HALF_W-1:0], mem_rdata[WORD_W-1:HALF_W]};
            i_stall  = mem_stall;
            buf_we   = !mem_stall;
            buf_wtag = w1_addr;
          end else if (hit_w1) begin
            mem_ren = 1'b1;
            i_rdata = {mem_rdata[HALF_W-1:0], buf_data[WORD_W-1:HALF_W]};
            i_stall = mem_stall;
          end else begin
            // Low half arrives first; the high half comes from the next word in S_HI.
            mem_ren = 1'b1;
            i_stall = 1'b1;
            if (!mem_stall) begin
              hold_d  = mem_rdata[HALF_W-1:0];
              addr_d  = i_addr;
              buf_we  = 1'b1;
              state_d = S_HI;
            end
          end
        end
        S_HI: begin
          if (i_addr != addr_q) begin
            i_stall = 1'b1;
            state_d = S_IDLE;
          end else begin
            mem_ren  = 1'b1;
            mem_addr = w1_addr;
            i_rdata  = {hold_q, mem_rdata[WORD_W-1:HALF_W]};
            i_stall  = mem_stall;
            buf_we   = !mem_stall;
            buf_wtag = w1_addr;
            if (!mem_stall) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
    end
  end
endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed table, corner sequences, random fetches.
module tb_fetch_aligner;
  import fetch_align_pkg::*;

`ifdef FETCH_ALIGN_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ren, i_wen, i_inv;
  logic [30:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_stall;
  logic [31:0] i_rdata;
  logic        mem_ren, mem_wen;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_stall;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  waddr_t exp_q[$];

  // Valid/tag of the buffer as the bench expects it
  bit     mb_v;
  waddr_t mb_t;

  fetch_aligner #(.HADDR_W(31)) dut (
    .clk(clk), .rst(rst), .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_inv(i_inv), .i_stall(i_stall), .i_rdata(i_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [29:0] a);
    logic [31:0] h;
    case (a)
      30'h80:  word_of = 32'h11223344;
      30'h101: word_of = 32'hAAAABBBB;
      30'h102: word_of = 32'hCCCCDDDD;
      30'h103: word_of = 32'h12345678;
      default: begin
        h = {2'b00, a} * 32'h9E3779B1;
        word_of = h ^ 32'h2545F491;
      end
    endcase
  endfunction

  always_comb mem_rdata = word_of(mem_addr);

  // 32 bits starting at halfword address a
  function automatic logic [31:0] exp_rdata(input logic [30:0] a);
    logic [29:0] w, w1;
    logic [31:0] lo_word, hi_word;
    w  = a[30:1];
    w1 = w + 30'd1;
    lo_word = word_of(w);
    hi_word = word_of(w1);
    if (a[0]) exp_rdata = {lo_word[15:0], hi_word[31:16]};
    else      exp_rdata = lo_word;
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected cache reads for one fetch, and the resulting buffer contents
  task automatic model_push(input logic [30:0] a);
    waddr_t w, w1;
    w  = a[30:1];
    w1 = w + 30'd1;
    if (!LB) begin
      exp_q.push_back(w);
      if (a[0]) exp_q.push_back(w1);
    end else if (!a[0]) begin
      if (!(mb_v && mb_t == w)) begin
        exp_q.push_back(w);
        mb_v = 1'b1; mb_t = w;
      end
    end else if (mb_v && mb_t == w) begin
      exp_q.push_back(w1);
      mb_t = w1;
    end else if (mb_v && mb_t == w1) begin
      exp_q.push_back(w);
    end else begin
      exp_q.push_back(w);
      exp_q.push_back(w1);
      mb_v = 1'b1; mb_t = w1;
    end
  endtask

  // Starts at a negedge; nstall<0 selects random mem_stall
  task automatic run_fetch(input logic [30:0] addr, input bit inv, input int nstall,
                           input logic [31:0] exp_data, input string nm, output int ncyc);
    int cyc;
    bit done;
    logic [31:0] got;
    waddr_t ea;
    i_addr = addr; i_ren = 1'b1; done = 1'b0; cyc = 0; got = '0;
    while (!done && cyc < 40) begin
      i_inv = inv && (cyc == 0);
      if (nstall >= 0) mem_stall = (cyc < nstall);
      else             mem_stall = ($urandom_range(0, 99) < 30);
      #1;
      if (mem_ren && !mem_stall) begin
        if (exp_q.size() == 0) begin
          check32({nm, "_extra_read"}, {2'b00, mem_addr}, 32'hFFFFFFFF);
        end else begin
          ea = exp_q.pop_front();
          check32({nm, "_raddr"}, {2'b00, mem_addr}, {2'b00, ea});
        end
      end
      if (!i_stall) begin
        done = 1'b1;
        got  = i_rdata;
      end
      cyc++;
      @(negedge clk);
    end
    i_inv = 1'b0;
    mem_stall = 1'b0;
    check32({nm, "_done"}, {31'd0, done}, 32'd1);
    check32({nm, "_rdata"}, got, exp_data);
    check32({nm, "_reads_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
    ncyc = cyc;
  endtask

  task automatic check_reset_outputs(input string nm);
    #1;
    check32({nm, "_mem_ren"}, {31'd0, mem_ren}, 32'd0);
    check32({nm, "_i_stall"}, {31'd0, i_stall}, 32'd0);
    check32({nm, "_i_rdata"}, i_rdata, 32'd0);
  endtask

  typedef struct {
    logic [30:0] addr;
    bit          inv;
    int          nstall;
    logic [31:0] data;
    int          nreads;
    logic [29:0] a0;
    logic [29:0] a1;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ncyc;
    int exp_cyc;
    logic [30:0] a;
    rst = 1'b1; i_ren = 1'b0; i_wen = 1'b0; i_inv = 1'b0;
    i_addr = '0; i_wdata = '0; mem_stall = 1'b0;
    mb_v = 1'b0; mb_t = '0;

    vecs[0] = '{31'h100, 1'b0, 2, 32'h11223344, 1, 30'h80, 30'h0};
    vecs[1] = '{31'h100, 1'b0, 0, 32'h11223344, LB ? 0 : 1, 30'h80, 30'h0};
    vecs[2] = '{31'h203, 1'b0, 0, 32'hBBBBCCCC, 2, 30'h101, 30'h102};
    vecs[3] = '{31'h205, 1'b0, 1, 32'hDDDD1234, LB ? 1 : 2, LB ? 30'h103 : 30'h102, 30'h103};
    vecs[4] = '{31'h7FFFFFFF, 1'b0, 0, exp_rdata(31'h7FFFFFFF), 2, 30'h3FFFFFFF, 30'h0};
    vecs[5] = '{31'h100, 1'b0, 0, 32'h11223344, 1, 30'h80, 30'h0};
    vecs[6] = '{31'h100, 1'b1, 0, 32'h11223344, 1, 30'h80, 30'h0};
    vecs[7] = '{31'h100, 1'b0, 0, 32'h11223344, 1, 30'h80, 30'h0};
    vecs[8] = '{31'hFF, 1'b0, 1, exp_rdata(31'hFF), LB ? 1 : 2, 30'h7F, 30'h80};
    vecs[9] = '{31'h100, 1'b0, 3, 32'h11223344, LB ? 0 : 1, 30'h80, 30'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    i_ren = 1'b1; i_addr = 31'h203;
    check_reset_outputs("in_reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].nreads >= 1) exp_q.push_back(vecs[i].a0);
      if (vecs[i].nreads >= 2) exp_q.push_back(vecs[i].a1);
      run_fetch(vecs[i].addr, vecs[i].inv, vecs[i].nstall, vecs[i].data,
                $sformatf("vec%0d", i), ncyc);
      exp_cyc = (vecs[i].nreads == 0) ? 1 : vecs[i].nstall + vecs[i].nreads;
      check32($sformatf("vec%0d_cycles", i), ncyc, exp_cyc);
    end

    // Reset while waiting for the high half
    i_addr = 31'h401;
    #1;
    check32("hi_rst_first_addr", {2'b00, mem_addr}, 32'h200);
    @(negedge clk);
    #1;
    check32("hi_rst_second_addr", {2'b00, mem_addr}, 32'h201);
    rst = 1'b1;
    check_reset_outputs("hi_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(30'h200);
    run_fetch(31'h400, 1'b0, 0, exp_rdata(31'h400), "after_hi_rst", ncyc);

    // Address change while in S_HI abandons the fetch
    i_addr = 31'h601;
    #1;
    check32("abandon_first_addr", {2'b00, mem_addr}, 32'h300);
    check32("abandon_first_stall", {31'd0, i_stall}, 32'd1);
    @(negedge clk);
    i_addr = 31'h600;
    #1;
    check32("abandon_stall", {31'd0, i_stall}, 32'd1);
    check32("abandon_no_read", {31'd0, mem_ren}, 32'd0);
    @(negedge clk);
    if (!LB) exp_q.push_back(30'h300);
    run_fetch(31'h600, 1'b0, 0, exp_rdata(31'h600), "after_abandon", ncyc);

    // Fresh start for the random phase
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mb_v = 1'b0;
    a = 31'h1000;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        i_ren = 1'b0; i_inv = 1'b1;
        #1;
        check32("ren_low_stall", {31'd0, i_stall}, 32'd0);
        check32("ren_low_mem_ren", {31'd0, mem_ren}, 32'd0);
        @(negedge clk);
        i_inv = 1'b0;
        if (LB) mb_v = 1'b0;
      end
      case ($urandom_range(0, 5))
        0, 1:    a = a + 31'd2;
        2:       a = a + 31'd1;
        3:       a = 31'h7FFFFFF8 + 31'($urandom_range(0, 7));
        default: a = 31'h1000 + 31'($urandom_range(0, 15));
      endcase
      model_push(a);
      run_fetch(a, 1'b0, -1, exp_rdata(a), $sformatf("rnd%0d", k), ncyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
